nx_ram_1rw_arb: RTL
===================

// Module: nx_ram_1rw_arb
// PURPOSE
//  Shares one single-port RAM (1RW, 1-cycle registered read) among NUM_REQ requesters.
//  - Round-robin arbitration.
//  - Optional post-reset zero-fill of the whole array.
//  - Returns read data tagged with the requester ID.
//  - Sits between engine-side table clients and the nx_ram_1rw instance; drives its cs/we/add/din/bwe.
// PARAMETERS
//  NUM_REQ        4    number of requesters (>=2)
//  WIDTH          64   data width (bwe is per-bit, WIDTH wide)
//  DEPTH          256  RAM entries; address width AW=$clog2(DEPTH)
//  INIT_ON_RESET  1    1: zero-fill all entries after reset before accepting requests
// PORTS  (IW=max(1,$clog2(NUM_REQ)))
//  clk        in   1             clock
//  rst_n      in   1             reset, asynchronous, active-low
//  req_valid  in   NUM_REQ       request valid per requester
//  req_ready  out  NUM_REQ       grant; transfer when valid&ready
//  req_we     in   NUM_REQ       1=write, 0=read
//  req_add    in   NUM_REQ*AW    flattened addresses, requester i at [i*AW +: AW]
//  req_din    in   NUM_REQ*WIDTH flattened write data
//  req_bwe    in   NUM_REQ*WIDTH flattened per-bit write enables
//  rsp_valid  out  1             read data valid (no backpressure)
//  rsp_id     out  IW            requester that issued the read
//  rsp_data   out  WIDTH         read data
//  init_done  out  1             1 once zero-fill is complete (or skipped)
//  ram_cs     out  1             RAM chip select
//  ram_we     out  1             RAM write enable
//  ram_add    out  AW            RAM address
//  ram_din    out  WIDTH         RAM write data
//  ram_bwe    out  WIDTH         RAM bit write enables
//  ram_dout   in   WIDTH         RAM registered read data
// BEHAVIOUR
//  Reset values: req_ready=0, rsp_valid=0, rsp_id=0, init_done=0, ram_cs=0, ptr=0, init_cnt=0.
//  FSM states:
//  - INIT: one write per cycle; ram_cs=ram_we=1, ram_add=init_cnt, ram_din=0, ram_bwe=all ones.
//    init_cnt increments each cycle. At init_cnt==DEPTH-1, go to RUN.
//    req_ready=0 throughout. init_done registers to 1 on the INIT->RUN edge.
//  - RUN: absorbing state; left only by reset.
//  Reset exits to INIT if INIT_ON_RESET=1, otherwise to RUN with init_done=1 after the first clk edge.
//  Arbitration (RUN only, combinational grant, one per cycle):
//  - Winner = first valid requester at or after ptr, wrapping modulo NUM_REQ.
//  - req_ready is one-hot on the winner, zero if none valid.
//  - ram_* are driven from the winner's fields; ram_cs=|req_valid; ram_we=winner's req_we.
//  - On a grant, ptr <= (winner+1) mod NUM_REQ; with no grant, ptr holds.
//  Response:
//  - A read granted at cycle N gives rsp_valid=1 and rsp_id=winner at cycle N+1.
//  - rsp_data = ram_dout, passed through combinationally; valid only while rsp_valid=1.
//  - Writes produce no response. Requesters must always accept responses.
//  Ordering:
//  - Write at N followed by a read of the same address at N+1 (any requester) returns the new data.
//  - Partial bwe merges with the existing contents.
//  Boundaries:
//  - req_add>=DEPTH is illegal; the simulation assertion fires and the address is forwarded unchanged.
//  - Requests held during INIT wait, with no loss.
//  Reset mid-operation: the asynchronous clear drops any pending response, returns ptr to 0 and restarts INIT at address 0.
// TESTING
//  - Init (DEPTH=8): release reset -> ram_we=1, add 0..7, din=0, bwe=all ones for 8 cycles; init_done=1 in cycle 9; req_ready=0 throughout.
//  - Read: req1 writes 0xA5 to addr 5, then req0 reads addr 5 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=0xA5.
//  - Fairness: all 4 requesters valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; sparse valid {1,3} -> 1,3,1,3.
//  - Bit enables: write 0xFFFF then 0x0000 with bwe=0x00FF to addr 2; read -> 0xFF00.
//  - RAW: req2 writes 0x1234 to addr 9 at N, req3 reads addr 9 at N+1 -> rsp at N+2 = 0x1234, rsp_id=3.
//  - Reset mid-op: drop rst_n the cycle after a read grant -> rsp_valid=0 immediately; after release, INIT restarts at addr 0.

Source files
------------

// File: rtl/nx_ram_1rw_arb.sv
// Round-robin arbiter that shares one 1RW single-port RAM (1-cycle registered read) among
// NUM_REQ requesters, with optional post-reset zero-fill and ID-tagged read responses.
module nx_ram_1rw_arb #(
  parameter  int NUM_REQ       = 4,
  parameter  int WIDTH         = 64,
  parameter  int DEPTH         = 256,
  parameter  int INIT_ON_RESET = 1,
  localparam int AW            = $clog2(DEPTH),
  localparam int IW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [NUM_REQ-1:0]       i_req_we,
  input  logic [NUM_REQ*AW-1:0]    i_req_add,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_din,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_bwe,
  output logic                     o_rsp_valid,
  output logic [IW-1:0]            o_rsp_id,
  output logic [WIDTH-1:0]         o_rsp_data,
  output logic                     o_init_done,
  output logic                     o_ram_cs,
  output logic                     o_ram_we,
  output logic [AW-1:0]            o_ram_add,
  output logic [WIDTH-1:0]         o_ram_din,
  output logic [WIDTH-1:0]         o_ram_bwe,
  input  logic [WIDTH-1:0]         i_ram_dout
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam state_t RESET_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW-1:0]     r_init_cnt;
  logic [IW-1:0]     r_ptr;
  logic              r_init_done;
  logic              r_rsp_valid;
  logic [IW-1:0]     r_rsp_id;

  logic              w_init_last;
  logic              w_run;
  logic              w_found;
  logic              w_grant;
  logic [IW-1:0]     w_win;
  logic              w_win_we;
  logic [AW-1:0]     w_win_add;
  logic [WIDTH-1:0]  w_win_din;
  logic [WIDTH-1:0]  w_win_bwe;

  function automatic logic [IW-1:0] f_wrap(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  assign w_init_last = (r_init_cnt == AW'(DEPTH - 1));
  // Grants open only once init_done is registered, so nothing is granted during reset.
  assign w_run       = (r_state == ST_RUN) && r_init_done;
  assign w_grant     = w_run && w_found;

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req_valid[f_wrap(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = f_wrap(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_win_we  = 1'b0;
    w_win_add = '0;
    w_win_din = '0;
    w_win_bwe = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == IW'(i)) begin
        w_win_we  = i_req_we[i];
        w_win_add = i_req_add[i*AW +: AW];
        w_win_din = i_req_din[i*WIDTH +: WIDTH];
        w_win_bwe = i_req_bwe[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = '0;
    o_ram_cs    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_add   = '0;
    o_ram_din   = '0;
    o_ram_bwe   = '0;
    case (r_state)
      ST_INIT: begin
        // Held off while reset is asserted so the RAM sees no access during reset.
        o_ram_cs  = rst_n;
        o_ram_we  = rst_n;
        o_ram_add = r_init_cnt;
        o_ram_bwe = '1;
        if (w_init_last) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_run) begin
          o_ram_cs  = w_found;
          o_ram_we  = w_found && w_win_we;
          o_ram_add = w_win_add;
          o_ram_din = w_win_din;
          o_ram_bwe = w_win_bwe;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          o_req_ready[i] = w_grant && (w_win == IW'(i));
        end
      end
      default: w_state_nxt = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RESET_STATE;
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_done <= (w_state_nxt == ST_RUN);
      if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      r_rsp_valid <= w_grant && !w_win_we;
      if (w_grant) r_ptr <= f_wrap(w_win, 1);
      if (w_grant && !w_win_we) r_rsp_id <= w_win;
    end
  end

  // Out-of-range addresses are illegal; they are still forwarded unchanged to the RAM.
  always_ff @(posedge clk) begin
    if (w_grant) assert (int'(w_win_add) < DEPTH);
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_data  = i_ram_dout;
  assign o_init_done = r_init_done;

endmodule
